// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   RESET_PC_DEF / IM_BASE_DEF / IM_WORDS_DEF : default parameter values
//   NOP_WORD                                  : bubble / faulted-fetch word
//   redir_state_e                             : redirect FSM states
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam int unsigned IM_WORDS_DEF = 4096;
  localparam logic [31:0] NOP_WORD     = 32'h0000_0000;

  typedef enum logic {
    NORMAL  = 1'b0,
    PENDING = 1'b1
  } redir_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
//   clk, reset        : clock, asynchronous active-high reset
//   stall, flush      : hold / bubble controls (flush has priority)
//   pc_p0, instr_p0,
//   fault_p0          : fetch-side PC, word (already nop'd on fault), fault bit
//   id_*              : registered decode-side view
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc_p0,
  input  logic [31:0] instr_p0,
  input  logic        fault_p0,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        id_fetch_fault
);

  // IF -> ID boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_instr       <= NOP_WORD;
      id_pc          <= RESET_PC;
      id_pc8         <= RESET_PC + 32'd8;
      id_valid       <= 1'b0;
      id_fetch_fault <= 1'b0;
    end else if (flush) begin
      // Bubble still records the PC so the link address stays meaningful.
      id_instr       <= NOP_WORD;
      id_pc          <= pc_p0;
      id_pc8         <= pc_p0 + 32'd8;
      id_valid       <= 1'b0;
      id_fetch_fault <= 1'b0;
    end else if (!stall) begin
      id_instr       <= instr_p0;
      id_pc          <= pc_p0;
      id_pc8         <= pc_p0 + 32'd8;
      id_valid       <= 1'b1;
      id_fetch_fault <= fault_p0;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Pipelined instruction-fetch stage.
//   clk, reset              : clock, asynchronous active-high reset
//   stall                   : freeze PC and IF/ID (hazard unit)
//   flush                   : turn this edge's IF/ID capture into a bubble
//   redirect_en/redirect_pc : taken branch/jump from ID
//   imem_addr / imem_rdata  : instruction ROM address / combinational data
//   id_*                    : IF/ID register outputs
// A redirect seen while stalled is parked in pending_pc and applied on the
// first unstalled edge, so it is never dropped.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter int unsigned IM_WORDS = IM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic        id_fetch_fault
);

  // Upper bound computed in 33 bits so a ROM ending at 2^32 cannot wrap.
  localparam logic [32:0] IM_SPAN  = 33'(IM_WORDS) << 2;
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + IM_SPAN;

  logic [31:0]  pc_p0, pc_nxt;
  logic [31:0]  pending_pc, pending_pc_nxt;
  redir_state_e state, state_nxt;
  logic         fault_p0;
  logic [31:0]  instr_p0;

  function automatic logic fetch_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_BASE) || ({1'b0, pc} >= IM_LIMIT);
  endfunction

  assign imem_addr = pc_p0;
  assign fault_p0  = fetch_fault(pc_p0);
  assign instr_p0  = fault_p0 ? NOP_WORD : imem_rdata;

  // PC / redirect FSM state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_p0      <= RESET_PC;
      pending_pc <= 32'd0;
      state      <= NORMAL;
    end else begin
      pc_p0      <= pc_nxt;
      pending_pc <= pending_pc_nxt;
      state      <= state_nxt;
    end
  end

  always_comb begin
    pc_nxt         = pc_p0;
    pending_pc_nxt = pending_pc;
    state_nxt      = state;
    case (state)
      NORMAL: begin
        if (!stall) begin
          pc_nxt = redirect_en ? redirect_pc : pc_p0 + 32'd4;
        end else if (redirect_en) begin
          pending_pc_nxt = redirect_pc;
          state_nxt      = PENDING;
        end
      end
      PENDING: begin
        if (stall) begin
          if (redirect_en) pending_pc_nxt = redirect_pc;
        end else begin
          // A fresh redirect is younger than the parked one, so it wins.
          pc_nxt    = redirect_en ? redirect_pc : pending_pc;
          state_nxt = NORMAL;
        end
      end
      default: state_nxt = NORMAL;
    endcase
  end

  if_id_reg #(
    .RESET_PC(RESET_PC)
  ) u_if_id_reg (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .pc_p0         (pc_p0),
    .instr_p0      (instr_p0),
    .fault_p0      (fault_p0),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc8        (id_pc8),
    .id_valid      (id_valid),
    .id_fetch_fault(id_fetch_fault)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage. ROM word at address A is {16'hA5A5, A[15:0]}.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc8;
  logic        id_valid;
  logic        id_fetch_fault;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .redirect_en   (redirect_en),
    .redirect_pc   (redirect_pc),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .id_instr      (id_instr),
    .id_pc         (id_pc),
    .id_pc8        (id_pc8),
    .id_valid      (id_valid),
    .id_fetch_fault(id_fetch_fault)
  );

  always #5 clk = ~clk;

  assign imem_rdata = {16'hA5A5, imem_addr[15:0]};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    step();
    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_en = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2;
    checks++; if (imem_addr !== 32'h3000) begin errors++; $display("FAIL rst_addr: got %h exp %h", imem_addr, 32'h3000); end
    checks++; if (id_instr !== 32'h0) begin errors++; $display("FAIL rst_instr: got %h exp %h", id_instr, 32'h0); end
    checks++; if (id_pc !== 32'h3000) begin errors++; $display("FAIL rst_pc: got %h exp %h", id_pc, 32'h3000); end
    checks++; if (id_pc8 !== 32'h3008) begin errors++; $display("FAIL rst_pc8: got %h exp %h", id_pc8, 32'h3008); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", id_valid); end
    checks++; if (id_fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b exp 0", id_fetch_fault); end
    apply_reset();
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_pc = 32'h3000 + 32'(4 * (i - 1));
      checks++; if (imem_addr !== exp_pc + 32'd4) begin errors++; $display("FAIL seq_addr%0d: got %h exp %h", i, imem_addr, exp_pc + 32'd4); end
      checks++; if (id_pc !== exp_pc) begin errors++; $display("FAIL seq_idpc%0d: got %h exp %h", i, id_pc, exp_pc); end
      checks++; if (id_pc8 !== exp_pc + 32'd8) begin errors++; $display("FAIL seq_pc8_%0d: got %h exp %h", i, id_pc8, exp_pc + 32'd8); end
      checks++; if (id_instr !== {16'hA5A5, exp_pc[15:0]}) begin errors++; $display("FAIL seq_instr%0d: got %h exp %h", i, id_instr, {16'hA5A5, exp_pc[15:0]}); end
      checks++; if (id_valid !== 1'b1 || id_fetch_fault !== 1'b0) begin errors++; $display("FAIL seq_vf%0d: got %b%b exp 10", i, id_valid, id_fetch_fault); end
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    repeat (4) step();
    checks++; if (imem_addr !== 32'h3010) begin errors++; $display("FAIL redir_pre: got %h exp %h", imem_addr, 32'h3010); end
    redirect_en = 1'b1; redirect_pc = 32'h3100;
    step();
    redirect_en = 1'b0;
    checks++; if (imem_addr !== 32'h3100) begin errors++; $display("FAIL redir_addr: got %h exp %h", imem_addr, 32'h3100); end
    checks++; if (id_pc !== 32'h3010 || id_instr !== 32'hA5A5_3010 || id_valid !== 1'b1) begin errors++; $display("FAIL redir_slot: got %h/%h/%b exp 00003010/a5a53010/1", id_pc, id_instr, id_valid); end
    step();
    checks++; if (imem_addr !== 32'h3104 || id_pc !== 32'h3100 || id_instr !== 32'hA5A5_3100) begin errors++; $display("FAIL redir_tgt: got %h/%h/%h exp 00003104/00003100/a5a53100", imem_addr, id_pc, id_instr); end
  endtask

  task automatic test_stall_redirect();
    // Starts at PC=0x3104, IF/ID holding 0x3100.
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h3200;
    step();
    redirect_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_addr !== 32'h3104 || id_pc !== 32'h3100 || id_instr !== 32'hA5A5_3100) begin errors++; $display("FAIL stall_hold%0d: got %h/%h/%h exp 00003104/00003100/a5a53100", i, imem_addr, id_pc, id_instr); end
      if (i < 2) step();
    end
    stall = 1'b0;
    step();
    checks++; if (imem_addr !== 32'h3200 || id_pc !== 32'h3104) begin errors++; $display("FAIL stall_apply: got %h/%h exp 00003200/00003104", imem_addr, id_pc); end
    step();
    checks++; if (imem_addr !== 32'h3204) begin errors++; $display("FAIL stall_normal: got %h exp %h", imem_addr, 32'h3204); end
    // Latest redirect during a stall wins.
    stall = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h3300;
    step();
    redirect_pc = 32'h3400;
    step();
    redirect_en = 1'b0; stall = 1'b0;
    step();
    checks++; if (imem_addr !== 32'h3400) begin errors++; $display("FAIL stall_latest: got %h exp %h", imem_addr, 32'h3400); end
  endtask

  task automatic test_flush();
    // Starts at PC=0x3400.
    stall = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (id_instr !== 32'h0 || id_valid !== 1'b0 || id_fetch_fault !== 1'b0) begin errors++; $display("FAIL flush_bubble: got %h/%b/%b exp 00000000/0/0", id_instr, id_valid, id_fetch_fault); end
    checks++; if (id_pc !== 32'h3400 || id_pc8 !== 32'h3408 || imem_addr !== 32'h3400) begin errors++; $display("FAIL flush_pc: got %h/%h/%h exp 00003400/00003408/00003400", id_pc, id_pc8, imem_addr); end
    stall = 1'b0;
    step();
    checks++; if (imem_addr !== 32'h3404 || id_pc !== 32'h3400 || id_instr !== 32'hA5A5_3400 || id_valid !== 1'b1) begin errors++; $display("FAIL flush_resume: got %h/%h/%h/%b exp 00003404/00003400/a5a53400/1", imem_addr, id_pc, id_instr, id_valid); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (imem_addr !== 32'h3408 || id_valid !== 1'b0 || id_pc !== 32'h3404) begin errors++; $display("FAIL flush_only: got %h/%b/%h exp 00003408/0/00003404", imem_addr, id_valid, id_pc); end
  endtask

  task automatic fault_case(input logic [31:0] tgt, input logic exp_fault);
    redirect_en = 1'b1; redirect_pc = tgt;
    step();
    redirect_en = 1'b0;
    step();
    checks++; if (id_pc !== tgt || id_fetch_fault !== exp_fault || id_valid !== 1'b1 || id_instr !== (exp_fault ? 32'h0 : {16'hA5A5, tgt[15:0]})) begin errors++; $display("FAIL fault_%h: got pc=%h f=%b v=%b i=%h exp f=%b", tgt, id_pc, id_fetch_fault, id_valid, id_instr, exp_fault); end
  endtask

  task automatic test_fault();
    fault_case(32'h3102, 1'b1);
    fault_case(32'h7000, 1'b1);
    fault_case(32'h6FFC, 1'b0);
    fault_case(32'h2FFC, 1'b1);
    fault_case(32'h3000, 1'b0);
    fault_case(32'hFFFF_FFFC, 1'b1);
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h exp %h", imem_addr, 32'h0); end
    step();
    checks++; if (id_pc !== 32'h0 || id_fetch_fault !== 1'b1 || id_pc8 !== 32'h8) begin errors++; $display("FAIL wrap_id: got %h/%b/%h exp 00000000/1/00000008", id_pc, id_fetch_fault, id_pc8); end
  endtask

  task automatic test_reset_pending();
    redirect_en = 1'b1; redirect_pc = 32'h3050;
    step();
    checks++; if (imem_addr !== 32'h3050) begin errors++; $display("FAIL rp_pre: got %h exp %h", imem_addr, 32'h3050); end
    stall = 1'b1; redirect_pc = 32'h3500;
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (imem_addr !== 32'h3000 || id_valid !== 1'b0 || id_pc !== 32'h3000) begin errors++; $display("FAIL rp_async: got %h/%b/%h exp 00003000/0/00003000", imem_addr, id_valid, id_pc); end
    step();
    stall = 1'b0; redirect_en = 1'b0; reset = 1'b0;
    step();
    checks++; if (imem_addr !== 32'h3004 || id_pc !== 32'h3000 || id_valid !== 1'b1) begin errors++; $display("FAIL rp_discard: got %h/%h/%b exp 00003004/00003000/1", imem_addr, id_pc, id_valid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall_redirect();
    test_flush();
    test_fault();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Pipelined instruction-fetch stage that sits directly upstream of decode in the five-stage MIPS core, replacing the single-cycle PC/NPC fetch path.
- Holds the PC register and drives the instruction-ROM address.
- Captures the fetched word into the IF/ID pipeline register.
- Applies stall, flush and branch/jump redirect, and flags fetch faults for the exception logic.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
IM_BASE, 32'h0000_3000, lowest legal fetch address
IM_WORDS, 4096, number of 32-bit words in instruction ROM; legal range is IM_BASE to IM_BASE+4*IM_WORDS-1

Ports:
clk  in  1  single clock, all state updates on the rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  hold PC and IF/ID (driven by hazard unit)
flush  in  1  replace IF/ID contents with a bubble on this edge
redirect_en  in  1  branch/jump taken, resolved in ID
redirect_pc  in  32  target address of the redirect
imem_addr  out  32  current fetch PC (combinational from PC register)
imem_rdata  in  32  instruction word from ROM, combinational on imem_addr
id_instr  out  32  IF/ID instruction word
id_pc  out  32  IF/ID PC
id_pc8  out  32  id_pc + 8, link address (delay-slot ISA)
id_valid  out  1  IF/ID holds a real instruction
id_fetch_fault  out  1  IF/ID instruction came from a misaligned or out-of-range PC

Behaviour:
- Reset is asynchronous and active-high; it applies immediately and overrides everything, including mid-stall and mid-pending.
- Reset values: PC=RESET_PC, id_instr=0, id_pc=RESET_PC, id_pc8=RESET_PC+8, id_valid=0, id_fetch_fault=0, pending state=NORMAL, pending_pc=0.
- Fault detect is combinational on PC. fault = PC[1:0]!=0, or PC<IM_BASE, or PC>=IM_BASE+4*IM_WORDS.
- When fault=1, the captured instruction is forced to 0 (nop), and the fault bit travels with it (id_valid=1).
- Redirect state machine has two states, NORMAL and PENDING. It stores pending_pc.
- NORMAL, stall=0:
  - redirect_en=1: PC<=redirect_pc.
  - redirect_en=0: PC<=PC+4.
- NORMAL, stall=1:
  - PC holds.
  - redirect_en=1: pending_pc<=redirect_pc and go to PENDING. A redirect raised during a stall is never lost.
- PENDING, stall=1:
  - PC holds.
  - redirect_en=1 overwrites pending_pc (latest wins).
- PENDING, stall=0:
  - redirect_en=1: PC<=redirect_pc.
  - redirect_en=0: PC<=pending_pc.
  - Either way, return to NORMAL.
- Delay slot: the instruction at PC when a redirect is applied is still captured into IF/ID on that edge. The stage never auto-kills the delay slot.
- IF/ID update priority, highest first:
  - flush=1: bubble. id_instr=0, id_valid=0, id_fetch_fault=0, id_pc=PC, id_pc8=PC+8. Flush wins over stall; the PC obeys stall regardless.
  - stall=1: IF/ID holds all fields.
  - Otherwise: id_instr=fault?0:imem_rdata, id_pc=PC, id_pc8=PC+8, id_valid=1, id_fetch_fault=fault.
- Arithmetic: all PC adds are 32-bit modulo 2^32. Wrap from 32'hFFFF_FFFC to 0 is legal arithmetic and is flagged as a fault by the range check.
- Latency: an instruction appears on id_* exactly one cycle after its PC appears on imem_addr (when not stalled).

Decomposition:
- Shared package holds:
  - RESET_PC, IM_BASE, IM_WORDS defaults
  - NOP word 32'h0000_0000
  - redirect-state enum {NORMAL, PENDING}
- One natural sub-module, if_id_reg: the IF/ID pipeline register with stall/flush priority.
- PC, next-PC logic and the pending FSM stay in if_stage.

Test Plan:
- Reset release, no stall/redirect, ROM returns distinct words -> imem_addr 0x3000, 0x3004, 0x3008...; id_pc lags by one cycle; id_valid=1 from the second edge; id_pc8=id_pc+8.
- Redirect at PC=0x3010, redirect_pc=0x3100, stall=0 -> next imem_addr=0x3100; word at 0x3010 (delay slot) appears on id_instr with id_valid=1.
- stall=1 for 3 cycles with redirect_en=1 (target 0x3200) in the first stall cycle -> PC and id_* frozen; after stall drops, imem_addr=0x3200 on the next edge; state returns to NORMAL.
- flush=1 together with stall=1 -> id_instr=0, id_valid=0; PC unchanged; next non-stall edge resumes from the held PC.
- redirect_pc=0x3102 (misaligned), then later 0x7000 (out of range) -> id_fetch_fault=1, id_instr=0, id_valid=1 for each.
- Assert reset mid-PENDING at PC=0x3050 -> immediately PC=0x3000, id_valid=0, state NORMAL; the pending target is discarded.
